// File: rtl/mem_bus_pkg.sv
// Shared memory-bus definitions: command codes,
// I/O register addresses and copy-engine states.
package mem_bus_pkg;

  localparam logic [1:0] MNONE  = 2'b00;
  localparam logic [1:0] MREAD  = 2'b01;
  localparam logic [1:0] MWRITE = 2'b11;

  localparam logic [8:0] LED_ADDR = 9'h100;
  localparam logic [8:0] SW_ADDR  = 9'h140;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_REQ,
    S_RD_CAP,
    S_WR,
    S_DONE
  } state_e;

endpackage

// File: rtl/mem_copy_engine_if.sv
// Shared memory bus: initiator drives command,
// address and write data; responder returns read data.
interface mem_copy_engine_if #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 16
);

  logic [1:0]        mem_cmd;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] write_data;
  logic [DATA_W-1:0] read_data;

  modport master (
    output mem_cmd,
    output mem_addr,
    output write_data,
    input  read_data
  );

  modport slave (
    input  mem_cmd,
    input  mem_addr,
    input  write_data,
    output read_data
  );

endinterface

// File: rtl/mem_copy_engine.sv
// Block copy / fill bus initiator. Bus outputs are
// decoded from state and pointer registers only.
module mem_copy_engine
  import mem_bus_pkg::*;
#(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 16,
  parameter int LEN_W  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              mode,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [ADDR_W-1:0] dst_addr,
  input  logic [LEN_W-1:0]  len,
  input  logic [DATA_W-1:0] fill_data,
  mem_copy_engine_if.master bus,
  output logic              busy,
  output logic              done,
  output logic [LEN_W-1:0]  words_left
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] src_q, src_d;
  logic [ADDR_W-1:0] dst_q, dst_d;
  logic [LEN_W-1:0]  left_q, left_d;
  logic [DATA_W-1:0] fill_q, fill_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              mode_q, mode_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      left_q  <= '0;
      fill_q  <= '0;
      data_q  <= '0;
      mode_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      left_q  <= left_d;
      fill_q  <= fill_d;
      data_q  <= data_d;
      mode_q  <= mode_d;
    end
  end

  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    dst_d   = dst_q;
    left_d  = left_q;
    fill_d  = fill_q;
    data_d  = data_q;
    mode_d  = mode_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          src_d  = src_addr;
          dst_d  = dst_addr;
          left_d = len;
          fill_d = fill_data;
          mode_d = mode;
          if (len == '0)
            state_d = S_DONE;
          else if (mode)
            state_d = S_WR;
          else
            state_d = S_RD_REQ;
        end
      end
      S_RD_REQ: state_d = S_RD_CAP;
      // RAM output is registered: data valid here
      S_RD_CAP: begin
        data_d  = bus.read_data;
        src_d   = src_q + 1'b1;
        state_d = S_WR;
      end
      S_WR: begin
        dst_d  = dst_q + 1'b1;
        left_d = left_q - 1'b1;
        if (left_q == LEN_W'(1))
          state_d = S_DONE;
        else if (mode_q)
          state_d = S_WR;
        else
          state_d = S_RD_REQ;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    bus.mem_cmd    = MNONE;
    bus.mem_addr   = '0;
    bus.write_data = '0;
    unique case (state_q)
      S_RD_REQ, S_RD_CAP: begin
        bus.mem_cmd  = MREAD;
        bus.mem_addr = src_q;
      end
      S_WR: begin
        bus.mem_cmd    = MWRITE;
        bus.mem_addr   = dst_q;
        bus.write_data = mode_q ? fill_q : data_q;
      end
      default: begin
        bus.mem_cmd    = MNONE;
        bus.mem_addr   = '0;
        bus.write_data = '0;
      end
    endcase
  end

  assign busy       = (state_q != S_IDLE);
  assign done       = (state_q == S_DONE);
  assign words_left = left_q;

endmodule

// File: tb/tb_mem_copy_engine.sv
// Directed bench for mem_copy_engine with a
// registered-output RAM and LED/switch registers.
module tb_mem_copy_engine;
  import mem_bus_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        mode;
  logic [8:0]  src_addr;
  logic [8:0]  dst_addr;
  logic [7:0]  len;
  logic [15:0] fill_data;
  logic        busy;
  logic        done;
  logic [7:0]  words_left;

  logic [15:0] ram [512];
  logic [15:0] rd_q;
  logic [7:0]  ledr;
  logic [7:0]  sw;
  logic        tb_we;
  logic [8:0]  tb_a;
  logic [15:0] tb_d;

  int n_cmp;
  int n_err;
  int w;
  int p;

  logic [15:0] cp_exp [3] = '{16'h1111, 16'h2222, 16'h3333};

  mem_copy_engine_if #(.ADDR_W(9), .DATA_W(16)) bus ();

  mem_copy_engine #(
    .ADDR_W(9), .DATA_W(16), .LEN_W(8)
  ) dut (
    .clk        (clk),
    .reset      (rst_n),
    .start      (start),
    .mode       (mode),
    .src_addr   (src_addr),
    .dst_addr   (dst_addr),
    .len        (len),
    .fill_data  (fill_data),
    .bus        (bus),
    .busy       (busy),
    .done       (done),
    .words_left (words_left)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (tb_we)
      ram[tb_a] <= tb_d;
    else if (bus.mem_cmd == MWRITE) begin
      if (bus.mem_addr == LED_ADDR)
        ledr <= bus.write_data[7:0];
      else
        ram[bus.mem_addr] <= bus.write_data;
    end
    if (bus.mem_addr == SW_ADDR)
      rd_q <= {8'h00, sw};
    else
      rd_q <= ram[bus.mem_addr];
  end

  assign bus.read_data =
    (bus.mem_cmd == MREAD) ? rd_q : 16'h0000;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %0h want %0h",
             tag, obs, exp);
    end
  endtask

  task automatic poke(input logic [8:0] a,
                      input logic [15:0] d);
    tb_we = 1'b1;
    tb_a  = a;
    tb_d  = d;
    tick();
    tb_we = 1'b0;
  endtask

  task automatic go(input logic m,
                    input logic [8:0] s,
                    input logic [8:0] d,
                    input logic [7:0] l,
                    input logic [15:0] f);
    mode      = m;
    src_addr  = s;
    dst_addr  = d;
    len       = l;
    fill_data = f;
    start     = 1'b1;
    tick();
    start     = 1'b0;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst_n = 1'b0;
    start = 1'b0;
    mode = 1'b0;
    src_addr = '0;
    dst_addr = '0;
    len = '0;
    fill_data = '0;
    sw = 8'h5A;
    ledr = 8'h00;
    tb_we = 1'b0;
    tb_a = '0;
    tb_d = '0;
    repeat (2) tick();

    chk("rst_cmd", 32'(bus.mem_cmd), 32'(MNONE));
    chk("rst_addr", 32'(bus.mem_addr), 0);
    chk("rst_wd", 32'(bus.write_data), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_left", 32'(words_left), 0);

    poke(9'h010, 16'h1111);
    poke(9'h011, 16'h2222);
    poke(9'h012, 16'h3333);
    poke(9'h013, 16'h4444);
    poke(9'h020, 16'hAAAA);
    poke(9'h061, 16'h0000);
    poke(9'h090, 16'h0000);
    rst_n = 1'b1;
    tick();

    // copy 3 words 0x10 -> 0x40
    go(1'b0, 9'h010, 9'h040, 8'd3, 16'h0);
    for (int c = 1; c <= 10; c++) begin
      w = (c - 1) / 3;
      p = (c - 1) % 3;
      if (c < 10) begin
        chk("cp_cmd", 32'(bus.mem_cmd),
            32'((p == 2) ? MWRITE : MREAD));
        chk("cp_addr", 32'(bus.mem_addr),
            (p == 2) ? 32'h40 + w : 32'h10 + w);
        chk("cp_left", 32'(words_left), 3 - w);
        chk("cp_busy", 32'(busy), 1);
        chk("cp_done", 32'(done), 0);
        if (p == 2)
          chk("cp_wd", 32'(bus.write_data),
              32'(cp_exp[w]));
        else
          chk("cp_wd0", 32'(bus.write_data), 0);
      end else begin
        chk("cp_done", 32'(done), 1);
        chk("cp_dcmd", 32'(bus.mem_cmd), 0);
        chk("cp_daddr", 32'(bus.mem_addr), 0);
        chk("cp_dleft", 32'(words_left), 0);
      end
      tick();
    end
    chk("cp_idle", 32'(busy), 0);
    chk("cp_r40", 32'(ram[9'h040]), 32'h1111);
    chk("cp_r41", 32'(ram[9'h041]), 32'h2222);
    chk("cp_r42", 32'(ram[9'h042]), 32'h3333);

    // fill 4 words of 0xBEEF at 0x80
    go(1'b1, 9'h000, 9'h080, 8'd4, 16'hBEEF);
    for (int c = 1; c <= 5; c++) begin
      if (c < 5) begin
        chk("fl_cmd", 32'(bus.mem_cmd),
            32'(MWRITE));
        chk("fl_addr", 32'(bus.mem_addr),
            32'h80 + c - 1);
        chk("fl_wd", 32'(bus.write_data),
            32'hBEEF);
        chk("fl_left", 32'(words_left), 5 - c);
        chk("fl_done", 32'(done), 0);
      end else begin
        chk("fl_done", 32'(done), 1);
        chk("fl_dcmd", 32'(bus.mem_cmd), 0);
        chk("fl_dwd", 32'(bus.write_data), 0);
      end
      tick();
    end
    chk("fl_r80", 32'(ram[9'h080]), 32'hBEEF);
    chk("fl_r83", 32'(ram[9'h083]), 32'hBEEF);

    // zero length
    go(1'b1, 9'h000, 9'h020, 8'd0, 16'h5555);
    chk("z_done", 32'(done), 1);
    chk("z_busy", 32'(busy), 1);
    chk("z_cmd1", 32'(bus.mem_cmd), 0);
    tick();
    chk("z_idle", 32'(done), 0);
    chk("z_cmd2", 32'(bus.mem_cmd), 0);
    chk("z_ram", 32'(ram[9'h020]), 32'hAAAA);

    // fill wrapping past 0x1FF
    go(1'b1, 9'h000, 9'h1FE, 8'd3, 16'h1234);
    chk("wr_a0", 32'(bus.mem_addr), 32'h1FE);
    tick();
    chk("wr_a1", 32'(bus.mem_addr), 32'h1FF);
    tick();
    chk("wr_a2", 32'(bus.mem_addr), 32'h000);
    tick();
    chk("wr_done", 32'(done), 1);
    tick();
    chk("wr_r1fe", 32'(ram[9'h1FE]), 32'h1234);
    chk("wr_r1ff", 32'(ram[9'h1FF]), 32'h1234);
    chk("wr_r000", 32'(ram[9'h000]), 32'h1234);

    // switches -> LEDs
    go(1'b0, 9'h140, 9'h100, 8'd1, 16'h0);
    repeat (3) tick();
    chk("io_done", 32'(done), 1);
    tick();
    chk("io_led", 32'(ledr), 32'h5A);

    // reset during second WR of a 4-word copy
    go(1'b0, 9'h010, 9'h060, 8'd4, 16'h0);
    repeat (5) tick();
    chk("rs_cmd", 32'(bus.mem_cmd), 32'(MWRITE));
    chk("rs_addr", 32'(bus.mem_addr), 32'h061);
    chk("rs_left", 32'(words_left), 3);
    #2 rst_n = 1'b0;
    #1;
    chk("rs_acmd", 32'(bus.mem_cmd), 0);
    chk("rs_aaddr", 32'(bus.mem_addr), 0);
    chk("rs_awd", 32'(bus.write_data), 0);
    chk("rs_abusy", 32'(busy), 0);
    chk("rs_adone", 32'(done), 0);
    chk("rs_aleft", 32'(words_left), 0);
    repeat (2) tick();
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick();
      chk("rs_nodone", 32'(done), 0);
    end
    chk("rs_r60", 32'(ram[9'h060]), 32'h1111);
    chk("rs_r61", 32'(ram[9'h061]), 32'h0000);

    // start while busy is ignored
    go(1'b0, 9'h010, 9'h070, 8'd2, 16'h0);
    tick();
    mode = 1'b1;
    dst_addr = 9'h090;
    len = 8'd5;
    fill_data = 16'h9999;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("ig_cmd", 32'(bus.mem_cmd), 32'(MWRITE));
    chk("ig_addr", 32'(bus.mem_addr), 32'h070);
    chk("ig_wd", 32'(bus.write_data), 32'h1111);
    repeat (4) tick();
    chk("ig_done", 32'(done), 1);
    tick();
    chk("ig_idle", 32'(busy), 0);

    // back-to-back start right after DONE
    go(1'b1, 9'h000, 9'h0A0, 8'd1, 16'h7777);
    chk("bb_cmd", 32'(bus.mem_cmd), 32'(MWRITE));
    chk("bb_addr", 32'(bus.mem_addr), 32'h0A0);
    tick();
    chk("bb_done", 32'(done), 1);
    tick();
    chk("ig_r70", 32'(ram[9'h070]), 32'h1111);
    chk("ig_r71", 32'(ram[9'h071]), 32'h2222);
    chk("ig_r90", 32'(ram[9'h090]), 32'h0000);
    chk("bb_ra0", 32'(ram[9'h0A0]), 32'h7777);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: sim did not finish");
    $fatal(1, "timeout");
  end

endmodule
